// File: rtl/fft_frame_controller.sv
// fft_frame_controller
//   Frame sequencer around an in-place radix-2 FFT engine. It collects one
//   frame of N = 2**N_LOG2 samples into bank A in bit-reversed order, kicks
//   the address generator, waits for the butterfly pipeline to drain, then
//   streams the result bank out in natural order through a 2-entry skid FIFO.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last   input sample stream (accepted in LOAD only)
//   ld_we/ld_addr/ld_data bank-A write port, bit-reversed address
//   agu_start/agu_busy/agu_done     address-generator handshake
//   rd_en/rd_addr/rd_bank/rd_data   result-bank read port, 1-cycle latency
//   m_valid/m_ready/m_data/m_last   output sample stream, natural order
//   frame_busy            high whenever a frame is not being loaded
//   err_framing           sticky: s_last disagreed with the sample position

package fft_consts;
    localparam int N_LOG2 = 3;
endpackage

module fft_frame_controller #(
    parameter int N_LOG2       = fft_consts::N_LOG2,
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              ld_we,
    output logic [N_LOG2-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic              agu_start,
    input  logic              agu_busy,
    input  logic              agu_done,
    output logic              rd_en,
    output logic [N_LOG2-1:0] rd_addr,
    output logic              rd_bank,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              frame_busy,
    output logic              err_framing
);

    localparam logic [N_LOG2-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_UNLOAD
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [N_LOG2-1:0]   r_ld_cnt;
    logic [3:0]          r_drain_cnt;
    logic [N_LOG2:0]     r_rd_cnt;       // reads issued this frame, 0..N
    logic                r_inflight;
    logic                r_inflight_last;
    logic [DATA_W-1:0]   r_fifo_data [2];
    logic [1:0]          r_fifo_last;
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_fcnt;
    logic                r_err;

    logic [N_LOG2-1:0]   w_ld_addr;
    logic                w_accept;
    logic                w_ld_last;
    logic                w_pop;
    logic                w_head_last;
    logic [1:0]          w_occ;
    logic                w_issue;
    logic                w_frame_done;
    logic                w_drain_done;
    logic                w_unused_busy;

    // agu_busy is observed by nobody; kept on the port for external checking.
    assign w_unused_busy = agu_busy;

    always_comb begin
        for (int i = 0; i < N_LOG2; i++) begin
            w_ld_addr[i] = r_ld_cnt[N_LOG2-1-i];
        end
    end

    assign w_accept     = (r_state == S_LOAD) && s_valid;
    assign w_ld_last    = (r_ld_cnt == LAST_IDX);
    assign w_pop        = (r_fcnt != 2'd0) && m_ready;
    assign w_head_last  = r_fifo_last[r_rptr];
    // Occupancy counts the slot freed by this cycle's pop, so a full-rate
    // stream keeps one read in flight and one entry buffered.
    assign w_occ        = r_fcnt - {1'b0, w_pop} + {1'b0, r_inflight};
    assign w_issue      = !r_rd_cnt[N_LOG2] && (w_occ < 2'd2);
    assign w_frame_done = w_pop && w_head_last;
    assign w_drain_done = (r_drain_cnt == 4'(DRAIN_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and control outputs
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        ld_we       = 1'b0;
        agu_start   = 1'b0;
        rd_en       = 1'b0;
        case (r_state)
            S_LOAD: begin
                s_ready = 1'b1;
                ld_we   = s_valid;
                if (s_valid && w_ld_last) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                agu_start = 1'b1;
                if (agu_done) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                rd_en = w_issue;
                if (w_frame_done) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Counters, read tracking, output FIFO, error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ld_cnt        <= '0;
            r_drain_cnt     <= '0;
            r_rd_cnt        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_last     <= '0;
            r_wptr          <= 1'b0;
            r_rptr          <= 1'b0;
            r_fcnt          <= '0;
            r_err           <= 1'b0;
        end else begin
            // Load counter wraps to 0 after sample N-1, ready for the next frame.
            if (w_accept) begin
                r_ld_cnt <= r_ld_cnt + 1'b1;
                if (s_last != w_ld_last) begin
                    r_err <= 1'b1;
                end
            end

            if (r_state == S_DRAIN) begin
                r_drain_cnt <= w_drain_done ? '0 : r_drain_cnt + 1'b1;
            end

            r_inflight      <= rd_en;
            r_inflight_last <= (rd_addr == LAST_IDX);
            if (rd_en) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end

            if (r_inflight) begin
                r_fifo_data[r_wptr] <= rd_data;
                r_fifo_last[r_wptr] <= r_inflight_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_fcnt <= r_fcnt + {1'b0, r_inflight} - {1'b0, w_pop};

            if ((r_state == S_UNLOAD) && w_frame_done) begin
                r_rd_cnt <= '0;
                r_wptr   <= 1'b0;
                r_rptr   <= 1'b0;
                r_fcnt   <= '0;
            end
        end
    end

    assign ld_addr     = w_ld_addr;
    assign ld_data     = s_data;
    assign rd_addr     = r_rd_cnt[N_LOG2-1:0];
    // In-place radix-2 ping-pongs banks each stage; odd stage count ends in B.
    assign rd_bank     = ((N_LOG2 % 2) == 1);
    assign m_valid     = (r_fcnt != 2'd0);
    assign m_data      = r_fifo_data[r_rptr];
    assign m_last      = m_valid && w_head_last;
    assign frame_busy  = (r_state != S_LOAD);
    assign err_framing = r_err;

    // The AGU must not report completion to a start it has not been given.
    a_done_outside_run: assert property (@(posedge clk) disable iff (!rst_n)
        !(agu_done && agu_start && (r_state != S_RUN)));

endmodule

// File: doc/fft_frame_controller.md
FFT_FRAME_CONTROLLER -- requirements
Module: fft_frame_controller

Interface
REQ-001 Parameters SHALL be N_LOG2 = fft_consts::N_LOG2 (N = 2^N_LOG2, N_LOG2 >= 2), DATA_W = 32 (packed complex sample width), and DRAIN_CYCLES = 4 (butterfly pipeline depth, 1..15).
REQ-002 The block SHALL have one clock; reset is synchronous and active-low. Ports are listed below.
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample accepted when s_valid && s_ready.
- s_data  in  DATA_W  input sample.
- s_last  in  1  producer marks the final sample of a frame.
- ld_we  out  1  bank-A write enable.
- ld_addr  out  N_LOG2  bank-A write address.
- ld_data  out  DATA_W  bank-A write data.
- agu_start  out  1  start request to the address generator.
- agu_busy  in  1  address generator running.
- agu_done  in  1  address generator finished; held until agu_start drops.
- rd_en  out  1  result-bank read enable; data returns exactly 1 cycle later.
- rd_addr  out  N_LOG2  result-bank read address.
- rd_bank  out  1  result bank, 0 = A, 1 = B.
- rd_data  in  DATA_W  read data, valid 1 cycle after rd_en.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_W  output sample, natural order.
- m_last  out  1  marks output index N-1.
- frame_busy  out  1  high in every state except LOAD.
- err_framing  out  1  sticky framing error flag.

Function
REQ-003 The FSM SHALL have the states LOAD, RUN, DRAIN and UNLOAD; LOAD is the reset state.
REQ-004 In LOAD: s_ready = 1. Each accepted sample k (0..N-1) SHALL write ld_we = 1, ld_addr = bit-reverse(k) over N_LOG2 bits and ld_data = s_data combinationally in the same cycle.
REQ-005 The N-th accepted sample SHALL move the FSM LOAD -> RUN, with s_ready = 0 from the next cycle.
REQ-006 s_last SHALL be checked against the sample position on every accepted sample. If s_last = 1 at k < N-1, or s_last = 0 at k = N-1, err_framing SHALL be set. The frame still closes at exactly N samples.
REQ-007 In RUN: agu_start = 1 and is held until agu_done = 1 is sampled. In that cycle the FSM moves to DRAIN and agu_start drops to 0 on the next cycle.
REQ-008 In DRAIN: a counter SHALL run for DRAIN_CYCLES cycles and then the FSM moves to UNLOAD. agu_start stays 0 throughout DRAIN.
REQ-009 rd_bank SHALL be constant: 1 (B) when N_LOG2 is odd, 0 (A) when N_LOG2 is even.
REQ-010 In UNLOAD: rd_addr SHALL step 0..N-1 in order. One address is issued per cycle while (buffered + in-flight) < 2; the in-flight read count is 0 or 1.
REQ-011 Returned rd_data SHALL be pushed into a 2-entry output FIFO. m_valid = FIFO non-empty and m_data = FIFO head. m_last = 1 when the head is address N-1.
REQ-012 With m_ready held high, throughput SHALL be 1 sample/cycle after the first read. There is no loss or duplication under any m_ready pattern.
REQ-013 The cycle after the m_last beat is accepted, the FSM SHALL return to LOAD, with all counters cleared and s_ready = 1.
REQ-014 s_valid asserted outside LOAD SHALL be ignored, because s_ready = 0; no writes occur.
REQ-015 agu_busy SHALL feed no output or transition; it is for assertion only. An assertion SHALL fire on agu_done = 1 outside RUN while agu_start = 1.
REQ-016 err_framing SHALL clear only on reset.

Reset
REQ-017 rst_n = 0 at a clock edge SHALL force, on the next cycle:
- state = LOAD, all counters = 0, FIFO empty, no read in flight.
- s_ready = 1, ld_we = 0, agu_start = 0, rd_en = 0, m_valid = 0, m_last = 0, frame_busy = 0, err_framing = 0.
REQ-018 Reset in any state (mid-load, RUN, DRAIN, mid-unload) SHALL abort the frame with no further ld_we, rd_en or m_valid beats. A read that was in flight at the time of reset SHALL be discarded.

Verification (N_LOG2 = 3, DRAIN_CYCLES = 4)
REQ-019 Load 8 samples d0..d7, s_last on d7 -> ld_addr sequence 0,4,2,6,1,5,3,7; RUN entered next cycle; err_framing = 0.
REQ-020 In RUN, hold agu_done low 20 cycles, then assert it -> agu_start high the whole time, low 1 cycle after agu_done; first rd_en exactly 4 cycles later; rd_bank = 1.
REQ-021 Unload with m_ready = 1 and a memory model returning value = address -> m_data 0..7 on 8 consecutive cycles, m_last only on 7, s_ready = 1 the next cycle.
REQ-022 Unload with m_ready toggling 1,0,0,1,... -> all 8 values delivered once, in order; rd_en never issued while FIFO + in-flight = 2.
REQ-023 s_last on sample 3 and absent on sample 7 -> err_framing set at sample 3 and still high at the end of the frame; frame proceeds normally; flag clears only via rst_n.
REQ-024 rst_n low for 1 cycle during UNLOAD after 3 outputs -> m_valid = 0 the next cycle, state LOAD, no further outputs.
